// File: rtl/bpsk_bit_sync.sv
// Symbol-timing recovery and hard-bit decision for the BPSK demodulator:
// transition-tracking DPLL (+/-1 sample per bit) feeding an integrate-and-dump filter.
module bpsk_bit_sync #(
  parameter int DW        = 14,
  parameter int SPB       = 64,
  parameter int ACC_W     = 24,
  parameter int HYST      = 256,
  parameter int WIN       = 2,
  parameter int LOCK_BITS = 16,
  parameter int DIFF      = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    carrier_locked,
  input  logic signed [DW-1:0]    demod_in,
  output logic                    bit_out,
  output logic                    bit_valid,
  output logic signed [ACC_W-1:0] soft_out,
  output logic                    sync_locked
);

  localparam int PH_W = $clog2(SPB);
  localparam int LC_W = $clog2(LOCK_BITS + 1);

  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(SPB - 1);
  localparam logic [PH_W-1:0] PH_HALF   = PH_W'(SPB / 2);
  localparam logic [PH_W-1:0] PH_WIN    = PH_W'(WIN);
  localparam logic [PH_W-1:0] PH_WIN_HI = PH_W'(SPB - WIN);
  localparam logic [LC_W-1:0] LOCK_MAX  = LC_W'(LOCK_BITS);

  localparam logic signed [DW-1:0] HYST_P = DW'(HYST);
  localparam logic signed [DW-1:0] HYST_N = -HYST_P;

  typedef enum logic [1:0] {CORR_NONE, CORR_ADV, CORR_RET} corr_e;

  logic [PH_W-1:0]         ph_q, ph_d;
  logic                    stall_q, stall_d;     // retard: repeat ph=0 once
  logic                    mid_q, mid_d;         // a bit is partially integrated
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    neg_q, neg_d;         // sign tracker, 1 = negative
  logic                    prev_raw_q, prev_raw_d;
  logic [LC_W-1:0]         lock_cnt_q, lock_cnt_d;
  corr_e                   corr_q, corr_d;
  logic                    seen_q, seen_d;       // first transition already taken
  logic                    ontime_q, ontime_d;
  logic                    bit_out_q, bit_out_d;
  logic                    bit_valid_q, bit_valid_d;
  logic signed [ACC_W-1:0] soft_q, soft_d;
  logic                    sync_locked_q, sync_locked_d;

  logic signed [ACC_W-1:0] samp_ext;
  logic signed [ACC_W-1:0] sum;
  logic                    neg_new;
  logic                    first_trans;
  logic                    seen_eff;
  corr_e                   corr_now, corr_eff;
  logic                    ontime_now, ontime_eff;
  logic                    raw;
  logic [LC_W-1:0]         lock_next;

  always_comb begin
    ph_d          = ph_q;
    stall_d       = stall_q;
    mid_d         = mid_q;
    acc_d         = acc_q;
    neg_d         = neg_q;
    prev_raw_d    = prev_raw_q;
    lock_cnt_d    = lock_cnt_q;
    corr_d        = corr_q;
    seen_d        = seen_q;
    ontime_d      = ontime_q;
    bit_out_d     = bit_out_q;
    bit_valid_d   = 1'b0;
    soft_d        = soft_q;
    sync_locked_d = sync_locked_q;

    samp_ext = {{(ACC_W-DW){demod_in[DW-1]}}, demod_in};
    sum      = mid_q ? (acc_q + samp_ext) : samp_ext;

    neg_new = neg_q;
    if (demod_in > HYST_P)      neg_new = 1'b0;
    else if (demod_in < HYST_N) neg_new = 1'b1;

    first_trans = en && (neg_new != neg_q) && !seen_q;

    if (ph_q == '0)           corr_now = CORR_NONE;
    else if (ph_q < PH_HALF)  corr_now = CORR_RET;
    else                      corr_now = CORR_ADV;
    ontime_now = (ph_q <= PH_WIN) || (ph_q >= PH_WIN_HI);

    // The sample being dumped can itself carry the bit's first transition.
    corr_eff   = first_trans ? corr_now : corr_q;
    ontime_eff = first_trans ? ontime_now : ontime_q;
    seen_eff   = seen_q || first_trans;

    raw       = ~sum[ACC_W-1];
    lock_next = lock_cnt_q;
    if (seen_eff) begin
      if (!ontime_eff)              lock_next = '0;
      else if (lock_cnt_q != LOCK_MAX) lock_next = lock_cnt_q + 1'b1;
    end

    if (en) begin
      neg_d = neg_new;
      acc_d = sum;
      mid_d = 1'b1;
      if (first_trans) begin
        seen_d   = 1'b1;
        corr_d   = corr_now;
        ontime_d = ontime_now;
      end
      if (stall_q) begin
        stall_d = 1'b0;
      end else if (ph_q == PH_LAST) begin
        ph_d          = (corr_eff == CORR_ADV) ? PH_W'(1) : '0;
        stall_d       = (corr_eff == CORR_RET);
        mid_d         = 1'b0;
        seen_d        = 1'b0;
        corr_d        = CORR_NONE;
        ontime_d      = 1'b0;
        soft_d        = sum;
        bit_out_d     = (DIFF != 0) ? (raw ^ prev_raw_q) : raw;
        prev_raw_d    = raw;
        bit_valid_d   = 1'b1;
        lock_cnt_d    = lock_next;
        sync_locked_d = (lock_next == LOCK_MAX);
      end else begin
        ph_d = ph_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !carrier_locked) begin
      ph_q          <= '0;
      stall_q       <= 1'b0;
      mid_q         <= 1'b0;
      acc_q         <= '0;
      neg_q         <= 1'b0;
      prev_raw_q    <= 1'b0;
      lock_cnt_q    <= '0;
      corr_q        <= CORR_NONE;
      seen_q        <= 1'b0;
      ontime_q      <= 1'b0;
      bit_out_q     <= 1'b0;
      bit_valid_q   <= 1'b0;
      soft_q        <= '0;
      sync_locked_q <= 1'b0;
    end else begin
      ph_q          <= ph_d;
      stall_q       <= stall_d;
      mid_q         <= mid_d;
      acc_q         <= acc_d;
      neg_q         <= neg_d;
      prev_raw_q    <= prev_raw_d;
      lock_cnt_q    <= lock_cnt_d;
      corr_q        <= corr_d;
      seen_q        <= seen_d;
      ontime_q      <= ontime_d;
      bit_out_q     <= bit_out_d;
      bit_valid_q   <= bit_valid_d;
      soft_q        <= soft_d;
      sync_locked_q <= sync_locked_d;
    end
  end

  assign bit_out     = bit_out_q;
  assign bit_valid   = bit_valid_q;
  assign soft_out    = soft_q;
  assign sync_locked = sync_locked_q;

endmodule

// File: tb/tb_bpsk_bit_sync.sv
// Directed bench for bpsk_bit_sync at SPB=16: raw-sign instance plus a differential-decode instance.
module tb_bpsk_bit_sync;

  localparam int A = 4000;

  logic              clk;
  logic              rst;
  logic              en;
  logic              carrier_locked;
  logic signed [13:0] demod_in;
  logic              bit_out, bit_valid, sync_locked;
  logic signed [23:0] soft_out;
  logic              d_bit_out, d_bit_valid, d_sync_locked;
  logic signed [23:0] d_soft_out;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int samp = 0;

  int                 cap_c[$];
  int                 cap_n[$];
  logic               cap_bit[$];
  logic               cap_sync[$];
  logic signed [23:0] cap_soft[$];
  logic               dcap_bit[$];

  bpsk_bit_sync #(.DW(14), .SPB(16), .ACC_W(24), .HYST(256), .WIN(2),
                  .LOCK_BITS(4), .DIFF(0)) dut (
    .clk(clk), .rst(rst), .en(en), .carrier_locked(carrier_locked),
    .demod_in(demod_in), .bit_out(bit_out), .bit_valid(bit_valid),
    .soft_out(soft_out), .sync_locked(sync_locked)
  );

  bpsk_bit_sync #(.DW(14), .SPB(16), .ACC_W(24), .HYST(256), .WIN(2),
                  .LOCK_BITS(4), .DIFF(1)) dut_d (
    .clk(clk), .rst(rst), .en(en), .carrier_locked(carrier_locked),
    .demod_in(demod_in), .bit_out(d_bit_out), .bit_valid(d_bit_valid),
    .soft_out(d_soft_out), .sync_locked(d_sync_locked)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clear_caps();
    cap_c.delete(); cap_n.delete(); cap_bit.delete();
    cap_sync.delete(); cap_soft.delete(); dcap_bit.delete();
    cyc = 0;
    samp = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; carrier_locked = 1'b1; demod_in = '0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    clear_caps();
  endtask

  // drivers: one clock per call; outputs sampled 1 time unit after the edge
  task automatic drive(input int v, input logic e, input logic cl);
    demod_in = 14'(v); en = e; carrier_locked = cl;
    @(posedge clk); #1;
    if (bit_valid) begin
      cap_c.push_back(cyc); cap_n.push_back(samp); cap_bit.push_back(bit_out);
      cap_sync.push_back(sync_locked); cap_soft.push_back(soft_out);
    end
    if (d_bit_valid) dcap_bit.push_back(d_bit_out);
    cyc++;
    if (e) samp++;
  endtask

  // samples n < off are +A; afterwards bit k of 'bits' spans 16 samples (1 = +A)
  task automatic run_stream(input int off, input int nsamp, input logic [15:0] bits,
                            input int gap);
    int lvl;
    for (int n = 0; n < nsamp; n++) begin
      if (n < off) lvl = A;
      else         lvl = bits[(n - off) / 16] ? A : -A;
      drive(lvl, 1'b1, 1'b1);
      repeat (gap) drive(-8000, 1'b0, 1'b1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; carrier_locked = 1'b1; demod_in = 14'(A);
    repeat (2) begin @(posedge clk); #1; end
    vec_cnt++; if (bit_out !== 1'b0) begin err_cnt++; $display("FAIL reset bit_out: got %b expected 0", bit_out); end
    vec_cnt++; if (bit_valid !== 1'b0) begin err_cnt++; $display("FAIL reset bit_valid: got %b expected 0", bit_valid); end
    vec_cnt++; if (soft_out !== 24'sd0) begin err_cnt++; $display("FAIL reset soft_out: got %0d expected 0", soft_out); end
    vec_cnt++; if (sync_locked !== 1'b0) begin err_cnt++; $display("FAIL reset sync_locked: got %b expected 0", sync_locked); end
    rst = 1'b0;
    clear_caps();
    repeat (15) drive(A, 1'b1, 1'b1);
    vec_cnt++; if (cap_n.size() != 0) begin err_cnt++; $display("FAIL reset early_valid: got %0d strobes expected 0", cap_n.size()); end
    drive(A, 1'b1, 1'b1);
    vec_cnt++;
    if (cap_n.size() != 1) begin
      err_cnt++; $display("FAIL reset first_bit count: got %0d expected 1", cap_n.size());
    end else if (cap_soft[0] !== 24'sd64000 || cap_bit[0] !== 1'b1) begin
      err_cnt++; $display("FAIL reset first_bit: got soft %0d bit %b expected 64000 1", cap_soft[0], cap_bit[0]);
    end
  endtask

  task automatic test_aligned();
    int    exp_n[7]    = '{15, 31, 47, 63, 79, 95, 111};
    logic  exp_bit[7]  = '{1, 0, 1, 1, 0, 1, 0};
    logic  exp_sync[7] = '{0, 0, 0, 0, 0, 1, 1};
    do_reset();
    run_stream(0, 112, 16'h002D, 0);
    vec_cnt++; if (cap_n.size() != 7) begin err_cnt++; $display("FAIL aligned count: got %0d expected 7", cap_n.size()); end
    for (int i = 0; i < 7; i++) begin
      if (i < cap_n.size()) begin
        vec_cnt++;
        if (cap_n[i] != exp_n[i] || cap_bit[i] !== exp_bit[i] || cap_sync[i] !== exp_sync[i] ||
            cap_soft[i] !== (exp_bit[i] ? 24'sd64000 : -24'sd64000)) begin
          err_cnt++;
          $display("FAIL aligned bit%0d: got n=%0d bit=%b soft=%0d sync=%b expected n=%0d bit=%b soft=%0d sync=%b",
                   i, cap_n[i], cap_bit[i], cap_soft[i], cap_sync[i], exp_n[i], exp_bit[i],
                   exp_bit[i] ? 64000 : -64000, exp_sync[i]);
        end
      end
    end
  endtask

  task automatic test_late();
    int   exp_n[6]    = '{15, 32, 49, 66, 82, 98};
    logic exp_bit[6]  = '{0, 1, 0, 1, 0, 1};
    int   exp_soft[6] = '{-40000, 44000, -52000, 60000, -64000, 64000};
    logic exp_sync[6] = '{0, 0, 0, 0, 1, 1};
    do_reset();
    run_stream(3, 99, 16'h002A, 0);
    vec_cnt++; if (cap_n.size() != 6) begin err_cnt++; $display("FAIL late count: got %0d expected 6", cap_n.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < cap_n.size()) begin
        vec_cnt++;
        if (cap_n[i] != exp_n[i] || cap_bit[i] !== exp_bit[i] || cap_sync[i] !== exp_sync[i] ||
            cap_soft[i] !== 24'(exp_soft[i])) begin
          err_cnt++;
          $display("FAIL late bit%0d: got n=%0d bit=%b soft=%0d sync=%b expected n=%0d bit=%b soft=%0d sync=%b",
                   i, cap_n[i], cap_bit[i], cap_soft[i], cap_sync[i], exp_n[i], exp_bit[i],
                   exp_soft[i], exp_sync[i]);
        end
      end
    end
  endtask

  task automatic test_early();
    int   exp_n[7]    = '{15, 30, 45, 60, 76, 92, 108};
    logic exp_bit[7]  = '{1, 0, 1, 0, 1, 0, 1};
    int   exp_soft[7] = '{40000, -44000, 52000, -60000, 64000, -64000, 0};
    logic exp_sync[7] = '{0, 0, 0, 0, 0, 1, 0};
    do_reset();
    run_stream(13, 93, 16'h000A, 0);
    // last bit: stays negative until ph=8, then positive -> late in-bit transition
    repeat (8) drive(-A, 1'b1, 1'b1);
    repeat (8) drive(A, 1'b1, 1'b1);
    vec_cnt++; if (cap_n.size() != 7) begin err_cnt++; $display("FAIL early count: got %0d expected 7", cap_n.size()); end
    for (int i = 0; i < 7; i++) begin
      if (i < cap_n.size()) begin
        vec_cnt++;
        if (cap_n[i] != exp_n[i] || cap_bit[i] !== exp_bit[i] || cap_sync[i] !== exp_sync[i] ||
            cap_soft[i] !== 24'(exp_soft[i])) begin
          err_cnt++;
          $display("FAIL early bit%0d: got n=%0d bit=%b soft=%0d sync=%b expected n=%0d bit=%b soft=%0d sync=%b",
                   i, cap_n[i], cap_bit[i], cap_soft[i], cap_sync[i], exp_n[i], exp_bit[i],
                   exp_soft[i], exp_sync[i]);
        end
      end
    end
  endtask

  task automatic test_en_gating();
    int   exp_c[3]   = '{45, 93, 141};
    logic exp_bit[3] = '{1, 0, 1};
    do_reset();
    run_stream(0, 48, 16'h0005, 2);
    vec_cnt++; if (cap_n.size() != 3) begin err_cnt++; $display("FAIL gating count: got %0d expected 3", cap_n.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < cap_n.size()) begin
        vec_cnt++;
        if (cap_c[i] != exp_c[i] || cap_bit[i] !== exp_bit[i] ||
            cap_soft[i] !== (exp_bit[i] ? 24'sd64000 : -24'sd64000)) begin
          err_cnt++;
          $display("FAIL gating bit%0d: got cycle=%0d bit=%b soft=%0d expected cycle=%0d bit=%b",
                   i, cap_c[i], cap_bit[i], cap_soft[i], exp_c[i], exp_bit[i]);
        end
      end
    end
  endtask

  task automatic test_carrier_drop();
    do_reset();
    run_stream(0, 64, 16'h000A, 0);
    vec_cnt++;
    if (cap_n.size() != 4 || cap_sync[cap_sync.size()-1] !== 1'b1) begin
      err_cnt++; $display("FAIL carrier prelock: got %0d strobes, last sync %b expected 4 strobes sync 1",
                          cap_n.size(), (cap_sync.size() > 0) ? cap_sync[cap_sync.size()-1] : 1'bx);
    end
    repeat (7) drive(-A, 1'b1, 1'b1);
    drive(-A, 1'b1, 1'b0);
    vec_cnt++;
    if (sync_locked !== 1'b0 || bit_valid !== 1'b0 || soft_out !== 24'sd0 || bit_out !== 1'b0) begin
      err_cnt++; $display("FAIL carrier clear: got sync=%b valid=%b soft=%0d bit=%b expected all 0",
                          sync_locked, bit_valid, soft_out, bit_out);
    end
    repeat (15) drive(-A, 1'b1, 1'b1);
    vec_cnt++; if (cap_n.size() != 4) begin err_cnt++; $display("FAIL carrier partial_bit: got %0d strobes expected 4", cap_n.size()); end
    drive(-A, 1'b1, 1'b1);
    vec_cnt++;
    if (cap_n.size() != 5) begin
      err_cnt++; $display("FAIL carrier restart count: got %0d expected 5", cap_n.size());
    end else if (cap_n[4] != 87 || cap_soft[4] !== -24'sd64000 || cap_sync[4] !== 1'b0) begin
      err_cnt++; $display("FAIL carrier restart: got n=%0d soft=%0d sync=%b expected n=87 soft=-64000 sync=0",
                          cap_n[4], cap_soft[4], cap_sync[4]);
    end
  endtask

  task automatic test_diff();
    logic exp_a[5] = '{1, 0, 1, 0, 1};
    logic exp_b[5] = '{0, 0, 1, 0, 1};
    do_reset();
    run_stream(0, 80, 16'h0013, 0);
    vec_cnt++; if (dcap_bit.size() != 5) begin err_cnt++; $display("FAIL diff count: got %0d expected 5", dcap_bit.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < dcap_bit.size()) begin
        vec_cnt++;
        if (dcap_bit[i] !== exp_a[i]) begin
          err_cnt++; $display("FAIL diff bit%0d: got %b expected %b", i, dcap_bit[i], exp_a[i]);
        end
      end
    end
    do_reset();
    run_stream(0, 80, 16'h000C, 0);
    vec_cnt++; if (dcap_bit.size() != 5) begin err_cnt++; $display("FAIL diff_inv count: got %0d expected 5", dcap_bit.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < dcap_bit.size()) begin
        vec_cnt++;
        if (dcap_bit[i] !== exp_b[i]) begin
          err_cnt++; $display("FAIL diff_inv bit%0d: got %b expected %b", i, dcap_bit[i], exp_b[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; carrier_locked = 1'b1; demod_in = '0;
    test_reset();
    test_aligned();
    test_late();
    test_early();
    test_en_gating();
    test_carrier_drop();
    test_diff();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/bpsk_bit_sync.md
Name: bpsk_bit_sync

Overview:
- Symbol-timing recovery and bit decision stage. Sits directly downstream of the Costas carrier loop and consumes its 14-bit signed baseband output.
- Runs a transition-tracking digital PLL (phase counter with ±1-sample correction per bit) and an integrate-and-dump matched filter.
- Emits hard bits with a one-cycle valid strobe, the integrated soft value, and a bit-sync lock flag.

Parameters:
- DW, 14, input sample width (signed).
- SPB, 64, samples per bit; even, 8..1024.
- ACC_W, 24, accumulator width; must be at least DW+clog2(SPB)+1.
- HYST, 256, sign-change hysteresis threshold, in input LSBs.
- WIN, 2, timing window in samples (±) counted as on-time for lock.
- LOCK_BITS, 16, consecutive on-time transitions needed to assert lock.
- DIFF, 1, 1 = differential decode (resolves the 180° Costas ambiguity); 0 = raw sign.

Ports:
- clk, in, 1, system clock; single clock domain.
- rst, in, 1, synchronous, active-high reset.
- en, in, 1, sample enable; state advances only on cycles with en=1.
- carrier_locked, in, 1, carrier-loop lock indication; 0 holds the block cleared.
- demod_in, in, DW, signed demodulated baseband sample.
- bit_out, out, 1, decided bit.
- bit_valid, out, 1, one-cycle strobe marking bit_out/soft_out as new.
- soft_out, out, ACC_W, signed integrated value of the last bit.
- sync_locked, out, 1, symbol-timing lock.

Behaviour:
- Reset: all outputs 0. Internal phase counter ph=0, acc=0, sign tracker=0 (positive), prev_raw=0, lock count=0, pending correction=none.
- carrier_locked=0: same clear as reset, applied synchronously every cycle. bit_valid never asserts while it is 0.
- en=0: all state holds and bit_valid=0.
- Sign tracker, updated on en cycles:
  - demod_in > HYST sets the tracker positive.
  - demod_in < -HYST sets it negative.
  - Otherwise it holds.
  - A tracker change is a transition, tagged with the ph value of that sample.
- Integrate: on an en cycle with ph=0 and no hold active, acc = demod_in; otherwise acc = acc + demod_in. Sign-extend demod_in to ACC_W; no saturation is needed given the ACC_W rule.
- Dump: on an en cycle with ph=SPB-1, the final sum S = acc + demod_in. On the next clk:
  - soft_out = S.
  - raw = (S >= 0).
  - bit_out = raw XOR prev_raw if DIFF=1, else raw. Then prev_raw = raw.
  - bit_valid = 1 for exactly one cycle.
  - Latency: one clk after the last sample of the bit.
- Timing error: only the first transition in each bit period is used; later transitions in the same bit are ignored.
  - p=0: no correction.
  - 1 <= p < SPB/2: retard.
  - SPB/2 <= p <= SPB-1: advance.
- Correction is applied at the wrap from ph=SPB-1:
  - none: ph goes to 0.
  - advance: ph goes to 1. The next bit integrates SPB-1 samples, starting with acc = demod_in at ph=1.
  - retard: ph goes to 0 and holds at 0 for one extra en cycle. The next bit integrates SPB+1 samples; the second ph=0 sample is accumulated.
  - The pending correction clears at the wrap.
- Lock, evaluated at each dump:
  - Bit whose first transition satisfied p <= WIN or p >= SPB-WIN: lock count increments, saturating at LOCK_BITS.
  - Bit with a transition outside the window: lock count = 0 and sync_locked = 0.
  - Bit with no transition: lock count unchanged.
  - sync_locked = 1 once the count reaches LOCK_BITS, registered together with bit_valid.
- Simultaneous events:
  - A transition at ph=SPB-1 while a dump is in progress belongs to the current bit.
  - A transition during the retard hold cycle is tagged p=0.
- rst or a carrier_locked drop mid-bit discards the partial bit; no bit_valid is produced for it.

Test Plan (SPB=16, HYST=256, WIN=2, LOCK_BITS=4, DIFF=0 unless stated):
- Reset: with en=1, drive rst high for 2 cycles -> all outputs 0, and no bit_valid for 15 cycles after release.
- Aligned NRZ: ±4000, bits 1,0,1,1, transitions at ph=0 -> bit_valid every 16 en cycles; bit_out 1,0,1,1; soft_out ±64000; sync_locked rises on the 4th transition bit.
- Late data: first transition at ph=3 -> retard; following bit spans 17 samples; phase converges to p=0 within 3 bits, then holds with no further corrections.
- Early data: first transition at ph=13 -> advance; following bit spans 15 samples; converges to p=0; a transition at ph=8 resets the lock count.
- en gating / carrier: with en toggling 1-of-3 cycles, the bit rate scales by 3 with identical bits. Dropping carrier_locked at ph=7 -> no bit_valid for that bit, and sync_locked=0.
- DIFF=1: raw sequence 1,1,0,0,1 -> bit_out 1,0,1,0,1. An inverted input stream yields the same output after the first bit.
